// File: rtl/i2c_pkg.sv
// Shared types for the byte-level I2C initiator: command codes, FSM states
// and the per-quarter SCL/SDA drive table.
package i2c_pkg;

  localparam int QTR_W = 10;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_STOP
  } i2c_state_t;

  function automatic i2c_state_t cmd_state(i2c_cmd_t c);
    case (c)
      CMD_START: return ST_START;
      CMD_WRITE: return ST_WRITE;
      CMD_READ:  return ST_READ;
      default:   return ST_STOP;
    endcase
  endfunction

  // Returns {scl, sda} for quarter q of a slot; data is the SDA level of a byte slot.
  function automatic logic [1:0] slot_drive(i2c_state_t st, logic [1:0] q,
                                            logic held, logic data);
    logic [1:0] d;
    d = 2'b11;
    case (st)
      ST_START: case (q)
        2'd0:    d = {~held, 1'b1};
        2'd1:    d = 2'b11;
        2'd2:    d = 2'b10;
        default: d = 2'b00;
      endcase
      ST_STOP: case (q)
        2'd0:    d = 2'b00;
        2'd1:    d = 2'b10;
        default: d = 2'b11;
      endcase
      ST_WRITE, ST_READ: d = {(q == 2'd1) || (q == 2'd2), data};
      default: d = 2'b11;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Command handshake plus the open-drain SCL/SDA pair of the I2C initiator.
interface i2c_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       ack_in;
  logic [7:0] dout;
  logic       ack_out;
  logic       done;
  logic       busy;
  logic       scl_o;
  logic       scl_i;
  logic       sda_o;
  logic       sda_i;

  modport ctrl (
    input  cmd_valid, cmd, din, ack_in, scl_i, sda_i,
    output cmd_ready, dout, ack_out, done, busy, scl_o, sda_o
  );

  modport host (
    output cmd_valid, cmd, din, ack_in, scl_i, sda_i,
    input  cmd_ready, dout, ack_out, done, busy, scl_o, sda_o
  );
endinterface

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period divider; hold freezes the count so the bus can stretch Q1.
module i2c_qtr_tick
  import i2c_pkg::*;
#(
  parameter int DIV = 70
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clear,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] qtr
);

  localparam logic [QTR_W-1:0] LAST = QTR_W'(DIV - 1);

  logic [QTR_W-1:0] cnt;

  assign tick = !hold && (cnt == LAST);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      qtr <= '0;
    end else if (clear) begin
      cnt <= '0;
      qtr <= '0;
    end else if (tick) begin
      cnt <= '0;
      qtr <= qtr + 2'd1;
    end else if (!hold) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C initiator: START / WRITE / READ / STOP sequencer with ACK
// sampling, clock stretching and registered open-drain drives.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 70
) (
  input logic              clk_sys,
  input logic              reset,
  i2c_master_ctrl_if.ctrl  bus
);

  i2c_state_t state_q, state_n, drv_st;
  logic [1:0] scl_sync, sda_sync, qtr, drv_q, drv, rel_age;
  logic [3:0] bit_q, drv_bit;
  logic [7:0] shreg, dout_q;
  logic       tick, hold, accept, fin, load, q2_first;
  logic       drv_msb, drv_ack, drv_sda, ack_r, ack_smp;
  logic       busy_q, done_q, ack_out_q, scl_q, sda_q;

  wire scl_s = scl_sync[1];
  wire sda_s = sda_sync[1];

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);
  assign fin    = tick && (qtr == 2'd3) &&
                  ((state_q == ST_START) || (state_q == ST_STOP) || (bit_q == 4'd8));
  // A low SCL only counts as stretching once our own release has crossed the synchronizer.
  assign hold   = (state_q == ST_IDLE) ||
                  ((qtr == 2'd1) && scl_q && (rel_age == 2'd2) && !scl_s);

  i2c_qtr_tick #(.DIV(CLK_DIV)) u_tick (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (accept),
    .hold    (hold),
    .tick    (tick),
    .qtr     (qtr)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Drives are computed for the quarter about to start, so the pins never lag the FSM.
  always_comb begin
    state_n = state_q;
    drv_st  = state_q;
    drv_q   = qtr + 2'd1;
    drv_bit = bit_q;
    drv_msb = shreg[7];
    drv_ack = ack_r;
    drv_sda = 1'b1;
    load    = 1'b0;
    if (accept) begin
      state_n = cmd_state(i2c_cmd_t'(bus.cmd));
      drv_st  = state_n;
      drv_q   = 2'd0;
      drv_bit = 4'd0;
      drv_msb = bus.din[7];
      drv_ack = bus.ack_in;
      load    = 1'b1;
    end else if (fin) begin
      state_n = ST_IDLE;
    end else if (tick) begin
      load = 1'b1;
      if (qtr == 2'd3) begin
        drv_bit = bit_q + 4'd1;
        drv_msb = shreg[6];
      end
    end
    case (drv_st)
      ST_WRITE: drv_sda = (drv_bit == 4'd8) ? 1'b1 : drv_msb;
      ST_READ:  drv_sda = (drv_bit == 4'd8) ? ~drv_ack : 1'b1;
      default:  drv_sda = 1'b1;
    endcase
    drv = slot_drive(drv_st, drv_q, busy_q, drv_sda);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      bit_q     <= '0;
      shreg     <= '0;
      ack_r     <= 1'b0;
      ack_smp   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_out_q <= 1'b0;
      dout_q    <= '0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      rel_age   <= '0;
      q2_first  <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      done_q   <= fin;
      q2_first <= tick && (qtr == 2'd1);
      if (!scl_q)               rel_age <= '0;
      else if (rel_age != 2'd2) rel_age <= rel_age + 2'd1;
      if (load) begin
        scl_q <= drv[1];
        sda_q <= drv[0];
      end
      if (accept) begin
        bit_q <= '0;
        shreg <= bus.din;
        ack_r <= bus.ack_in;
      end else if (tick && (qtr == 2'd3)) begin
        bit_q <= bit_q + 4'd1;
        if (state_q == ST_WRITE) shreg <= {shreg[6:0], 1'b0};
      end else if (q2_first && (state_q == ST_READ) && (bit_q != 4'd8)) begin
        shreg <= {shreg[6:0], sda_s};
      end
      if (q2_first && (state_q == ST_WRITE) && (bit_q == 4'd8)) ack_smp <= ~sda_s;
      if (fin) begin
        case (state_q)
          ST_START: busy_q    <= 1'b1;
          ST_STOP:  busy_q    <= 1'b0;
          ST_WRITE: ack_out_q <= ack_smp;
          ST_READ:  dout_q    <= shreg;
          default:  ;
        endcase
      end
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.ack_out   = ack_out_q;
  assign bus.dout      = dout_q;
  assign bus.scl_o     = scl_q;
  assign bus.sda_o     = sda_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural responder on the wired-AND bus.
module tb_i2c_master_ctrl;
  localparam int D = 4;
  localparam int SHORT_LAT = 4 * D + 1;
  localparam int LONG_LAT  = 36 * D + 1;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  i2c_master_ctrl_if bus();

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  // Responder side: stretch and ACK/data levels, written only by the monitor.
  logic       stretch = 1'b0;
  logic       resp_sda = 1'b1;
  logic       stretch_arm = 1'b0;
  logic       resp_ack = 1'b0;
  logic [7:0] resp_byte = 8'h00;
  logic       prev_scl = 1'b1;
  logic [1:0] cur_cmd = 2'd0;
  int         fall_cnt = 0, rise_cnt = 0, stretch_left = 0;
  logic [8:0] rise_bits = '0;

  assign bus.scl_i = bus.scl_o & ~stretch;
  assign bus.sda_i = bus.sda_o & resp_sda;

  always @(negedge clk_sys) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      cur_cmd   = bus.cmd;
      fall_cnt  = 0;
      rise_cnt  = 0;
      rise_bits = '0;
    end else begin
      if (prev_scl && !bus.scl_o) fall_cnt++;
      if (!prev_scl && bus.scl_o) begin
        if (stretch_arm && cur_cmd == 2'd1 && rise_cnt == 3) begin
          stretch      = 1'b1;
          stretch_left = 37;
        end
        rise_bits = {rise_bits[7:0], bus.sda_o};
        rise_cnt++;
      end else if (stretch) begin
        stretch_left--;
        if (stretch_left == 0) stretch = 1'b0;
      end
    end
    prev_scl = bus.scl_o;
    case (cur_cmd)
      2'd1:    resp_sda = !(resp_ack && fall_cnt == 8);
      2'd2:    resp_sda = (fall_cnt < 8) ? resp_byte[7 - fall_cnt] : 1'b1;
      default: resp_sda = 1'b1;
    endcase
  end

  int n_err = 0, n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Issues one command and returns the cycle index of done (acceptance cycle = 0).
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic a,
                         output int lat);
    int w;
    w = 0;
    while (!bus.cmd_ready && w < 200) begin tick_n(1); w++; end
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd = c; bus.din = d; bus.ack_in = a; bus.cmd_valid = 1'b1;
    tick_n(1);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 5000) begin tick_n(1); lat++; end
  endtask

  typedef struct {
    logic [1:0] c;
    logic [7:0] d;
    logic       a;
    logic       r_ack;
    logic [7:0] r_byte;
    int         lat;
    logic       e_ack;
    logic [7:0] e_dout;
    logic       e_busy;
    logic       chk_bits;
    logic [8:0] e_bits;
  } vec_t;

  vec_t tv[10];

  initial begin
    int lat;
    tv[0] = '{2'd0, 8'h00, 1'b0, 1'b0, 8'h00, SHORT_LAT, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000};
    tv[1] = '{2'd1, 8'hD0, 1'b0, 1'b1, 8'h00, LONG_LAT,  1'b1, 8'h00, 1'b1, 1'b1, 9'h1A1};
    tv[2] = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, SHORT_LAT, 1'b1, 8'h00, 1'b0, 1'b0, 9'h000};
    tv[3] = '{2'd0, 8'h00, 1'b0, 1'b0, 8'h00, SHORT_LAT, 1'b1, 8'h00, 1'b1, 1'b0, 9'h000};
    tv[4] = '{2'd1, 8'hD1, 1'b0, 1'b1, 8'h00, LONG_LAT,  1'b1, 8'h00, 1'b1, 1'b1, 9'h1A3};
    tv[5] = '{2'd2, 8'h00, 1'b0, 1'b0, 8'h5A, LONG_LAT,  1'b1, 8'h5A, 1'b1, 1'b1, 9'h1FF};
    tv[6] = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, SHORT_LAT, 1'b1, 8'h5A, 1'b0, 1'b0, 9'h000};
    tv[7] = '{2'd1, 8'h3C, 1'b0, 1'b0, 8'h00, LONG_LAT,  1'b0, 8'h5A, 1'b0, 1'b1, 9'h079};
    tv[8] = '{2'd2, 8'h00, 1'b1, 1'b0, 8'hA5, LONG_LAT,  1'b0, 8'hA5, 1'b0, 1'b1, 9'h1FE};
    tv[9] = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, SHORT_LAT, 1'b0, 8'hA5, 1'b0, 1'b0, 9'h000};

    bus.cmd_valid = 1'b0; bus.cmd = 2'd0; bus.din = 8'h00; bus.ack_in = 1'b0;
    tick_n(3);
    chk("rst_scl", bus.scl_o, 1);
    chk("rst_sda", bus.sda_o, 1);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack_out, 0);
    chk("rst_dout", bus.dout, 8'h00);
    reset = 1'b0;
    tick_n(2);

    for (int i = 0; i < 10; i++) begin
      resp_ack  = tv[i].r_ack;
      resp_byte = tv[i].r_byte;
      run_cmd(tv[i].c, tv[i].d, tv[i].a, lat);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_ready_at_done", i), bus.cmd_ready, 1);
      chk($sformatf("v%0d_ack_out", i), bus.ack_out, tv[i].e_ack);
      chk($sformatf("v%0d_dout", i), bus.dout, tv[i].e_dout);
      chk($sformatf("v%0d_busy", i), bus.busy, tv[i].e_busy);
      if (tv[i].chk_bits) chk($sformatf("v%0d_sda_at_rise", i), rise_bits, tv[i].e_bits);
    end

    // Stretch of 37 cycles in Q1 of the fourth data bit.
    tick_n(3);
    run_cmd(2'd0, 8'h00, 1'b0, lat);
    resp_ack = 1'b1;
    stretch_arm = 1'b1;
    run_cmd(2'd1, 8'hB7, 1'b0, lat);
    stretch_arm = 1'b0;
    chk("stretch_lat", lat, LONG_LAT + 37);
    chk("stretch_ack", bus.ack_out, 1);
    chk("stretch_bits", rise_bits, 9'h16F);
    tick_n(1);
    chk("done_one_cycle", bus.done, 0);

    // Repeated start while the bus is owned.
    run_cmd(2'd0, 8'h00, 1'b0, lat);
    chk("rs_busy_before", bus.busy, 1);
    bus.cmd = 2'd0; bus.cmd_valid = 1'b1;
    tick_n(1);
    bus.cmd_valid = 1'b0;
    chk("rs_q0_scl", bus.scl_o, 0);
    chk("rs_q0_sda", bus.sda_o, 1);
    tick_n(D);
    chk("rs_q1_scl", bus.scl_o, 1);
    chk("rs_q1_sda", bus.sda_o, 1);
    tick_n(D);
    chk("rs_q2_scl", bus.scl_o, 1);
    chk("rs_q2_sda", bus.sda_o, 0);
    lat = 2 * D + 1;
    while (!bus.done && lat < 5000) begin tick_n(1); lat++; end
    chk("rs_lat", lat, SHORT_LAT);
    chk("rs_busy", bus.busy, 1);

    // Reset in the middle of READ bit 4.
    resp_byte = 8'hFF;
    bus.cmd = 2'd2; bus.ack_in = 1'b0; bus.cmd_valid = 1'b1;
    tick_n(1);
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (rise_cnt < 5 && lat < 2000) begin tick_n(1); lat++; end
    chk("mid_read_reached", (rise_cnt >= 5), 1);
    reset = 1'b1;
    tick_n(1);
    chk("mr_scl", bus.scl_o, 1);
    chk("mr_sda", bus.sda_o, 1);
    chk("mr_busy", bus.busy, 0);
    chk("mr_ready", bus.cmd_ready, 1);
    chk("mr_done", bus.done, 0);
    tick_n(2);
    reset = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      tick_n(1);
      if (bus.done) lat++;
    end
    chk("mr_no_done", lat, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Byte-level I2C initiator on `clk_sys`. It drives the open-drain SCL/SDA pair toward an I2C responder such as the DS1307 RTC model, the other end of the existing bus. A sequencer issues four commands: START, WRITE byte, READ byte and STOP. The block generates bus timing, samples the ACK and supports clock stretching. It lets system-side logic (RTC preload, config EEPROM) reach I2C devices without going through the Next core.

## Interface
Parameters:
- `CLK_DIV`, default 70: `clk_sys` cycles per SCL quarter-period. 28 MHz / (4·70) = 100 kHz. Legal range 2..1023.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command strobe; accepted when `cmd_valid & cmd_ready`.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd`  in  2  command code: 0 = START, 1 = WRITE, 2 = READ, 3 = STOP.
- `din`  in  8  byte for WRITE, MSB first.
- `ack_in`  in  1  for READ: 1 = master ACKs (SDA low), 0 = NACK.
- `dout`  out  8  byte received by READ; valid when `done` is high.
- `ack_out`  out  1  for WRITE: 1 = slave ACKed; valid when `done` is high.
- `done`  out  1  one-cycle pulse when a command completes.
- `busy`  out  1  high between START completion and STOP completion (bus owned).
- `scl_o`  out  1  SCL drive; 1 = release, 0 = pull low.
- `scl_i`  in  1  sensed SCL, used for stretching.
- `sda_o`  out  1  SDA drive; 1 = release, 0 = pull low.
- `sda_i`  in  1  sensed SDA.

## Operation
- FSM states: IDLE, START, WRITE, READ, STOP. Every bus-bit slot lasts 4 quarters, Q0..Q3.
- A command is accepted only in IDLE. `cmd`, `din` and `ack_in` are registered on acceptance. Q0 begins on the next cycle.
- START takes 1 slot:
  - Q0: SDA = 1, SCL = 0 if `busy`, else SCL = 1.
  - Q1: SDA = 1, SCL = 1.
  - Q2: SDA = 0, SCL = 1.
  - Q3: SDA = 0, SCL = 0.
  - Sets `busy`. Issuing START while `busy` produces a repeated start.
- WRITE takes 9 slots: 8 data bits MSB first, then 1 ACK slot.
  - Data bit: SDA is set in Q0 with SCL low. SCL is released in Q1 and Q2 and driven low in Q3.
  - ACK slot: SDA is released. `sda_i` is sampled on the first cycle of Q2, and `ack_out` = ~`sda_i`.
- READ takes 9 slots.
  - SDA is released for the 8 data slots. Each bit is sampled on the first cycle of Q2 and shifted into `dout` MSB first.
  - ACK slot: SDA = ~`ack_in`.
- STOP takes 1 slot:
  - Q0: SDA = 0, SCL = 0.
  - Q1: SDA = 0, SCL = 1.
  - Q2: SDA = 1, SCL = 1.
  - Q3: both released.
  - Clears `busy`.
- Clock stretching: the Q1 → Q2 transition is held while `scl_i` = 0. The quarter counter does not advance until `scl_i` is seen high, so stretching has no timeout.
- WRITE or READ commanded while `busy` = 0 still executes. SCL starts from the released level and the first Q0 pulls it low. This is legal and not flagged.
- STOP while `busy` = 0 executes normally.
- A NACK on WRITE does not abort. The sequencer decides what happens next.
- `dout` holds its value until the next READ completes. `ack_out` holds until the next WRITE completes.
- Reset, including mid-transfer, returns immediately to IDLE. Both lines are released and `busy` = 0. No STOP is generated.

## Timing
- Reset values:
  - `scl_o` = 1, `sda_o` = 1, `cmd_ready` = 1.
  - `done` = 0, `busy` = 0, `ack_out` = 0, `dout` = 0x00.
- Each quarter lasts exactly `CLK_DIV` cycles, plus any stretch cycles in Q1.
- Latency without stretching, from the acceptance edge to `done`:
  - START and STOP: 4·`CLK_DIV` + 1 cycles.
  - WRITE and READ: 36·`CLK_DIV` + 1 cycles.
- `done` and `cmd_ready` rise in the same cycle. A new command may be accepted in that cycle, so back-to-back commands have zero idle gap.
- `scl_o` and `sda_o` come straight from registers with no glitches. SDA changes only in Q0, or in Q2 for START/STOP.
- `scl_i` and `sda_i` pass through a 2-flop synchronizer inside the block. The sample point (Q2) accounts for that 2-cycle delay, which requires `CLK_DIV` ≥ 2.

## Structure
- Package `i2c_pkg`:
  - `i2c_cmd_t` enum (START, WRITE, READ, STOP).
  - `i2c_state_t` enum.
  - `QTR_W` = 10, the quarter-counter width.
- Sub-module `i2c_qtr_tick`:
  - Quarter-period divider with a `hold` input for stretching.
  - Outputs a one-cycle `tick` and the 2-bit quarter index.
- Top level: FSM, 4-bit bit counter, 8-bit shift register, synchronizers.

## Test plan
- START, WRITE 0xD0, STOP with a DS1307-style responder ACKing, `CLK_DIV` = 4 → `ack_out` = 1. SDA shows 1101_0000 on the SCL rising edges. `done` fires 145 cycles after WRITE is accepted.
- START, WRITE 0xD1, READ with `ack_in` = 0 while the responder drives 0x5A, STOP → `dout` = 0x5A. SDA is released (1) in the 9th slot. `busy` = 0 after STOP.
- WRITE to an absent device (SDA pulled up) → `ack_out` = 0 and the FSM returns to IDLE with no hang.
- Responder holds SCL low for 37 cycles in the Q1 of bit 3 → completion is delayed by exactly 37 cycles and the data is intact.
- START then START again (repeated start) → SCL is low at the second START's Q0 and SDA falls while SCL is high.
- Assert `reset` in the middle of READ bit 4 → the next cycle shows `scl_o` = `sda_o` = 1, `busy` = 0, `cmd_ready` = 1, and no `done` pulse.
